// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg
// Shared types and constants for the MAC_4BIT job sequencer.
//   mac_seq_state_t : sequencer state encoding
//   MAC_DW          : operand / result window width of the MAC slice
//   OSEL_W          : width of the slice output-window select
//   MAC_OSEL_MAX    : highest legal output-window select
//   clamp_osel()    : limits a requested window select to the legal range
package mac_seq_pkg;

  localparam int MAC_DW = 4;
  localparam int OSEL_W = 6;
  localparam logic [OSEL_W-1:0] MAC_OSEL_MAX = OSEL_W'(16);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PAD   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } mac_seq_state_t;

  // The slice has no window above MAC_OSEL_MAX; a larger request is pinned
  // to the top window rather than handed to the slice as an undefined select.
  function automatic logic [OSEL_W-1:0] clamp_osel(input logic [OSEL_W-1:0] sel);
    return (sel > MAC_OSEL_MAX) ? MAC_OSEL_MAX : sel;
  endfunction

endpackage

// File: rtl/mac_4bit_seq.sv
// mac_4bit_seq
// Job sequencer for one MAC_4BIT slice. Latches a job configuration on
// start, streams operand/coefficient pairs into the slice, controls the
// first-product clear/round, then captures the slice output window and
// offers it on a valid/ready result port.
// Ports:
//   MAC_ACC_CLK, MAC_SEQ_RST       : clock, synchronous active-high reset
//   start, cfg_*                   : job request and configuration
//   busy                           : sequencer not idle
//   s_valid/s_ready/s_oper/s_coef  : sample stream in
//   MAC_OPER_DATA, MAC_COEF_DATA   : operands to the slice
//   EFPGA_MATHB_CLK_EN             : accumulator load enable
//   MAC_ACC_CLEAR, MAC_ACC_RND     : first-product feedback control
//   MAC_ACC_SAT, MAC_OUT_SEL, MAC_TC : latched job configuration
//   MAC_OUT                        : slice result window
//   r_valid/r_ready/r_data         : result port
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_PAD   | zero-length job: one load of zero operands
// ST_RUN   | accepting samples, one product per accept
// ST_DRAIN | accumulator settled, capture MAC_OUT
// ST_HOLD  | result presented until r_ready
module mac_4bit_seq
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              MAC_ACC_CLK,
  input  logic              MAC_SEQ_RST,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [OSEL_W-1:0] cfg_out_sel,
  input  logic              cfg_sat,
  input  logic              cfg_rnd,
  input  logic              cfg_tc,
  output logic              busy,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [MAC_DW-1:0] s_oper,
  input  logic [MAC_DW-1:0] s_coef,
  output logic [MAC_DW-1:0] MAC_OPER_DATA,
  output logic [MAC_DW-1:0] MAC_COEF_DATA,
  output logic              EFPGA_MATHB_CLK_EN,
  output logic              MAC_ACC_CLEAR,
  output logic              MAC_ACC_RND,
  output logic              MAC_ACC_SAT,
  output logic [OSEL_W-1:0] MAC_OUT_SEL,
  output logic              MAC_TC,
  input  logic [MAC_DW-1:0] MAC_OUT,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [MAC_DW-1:0] r_data
);

  mac_seq_state_t    state_q, state_d;
  logic [LEN_W-1:0]  cnt;
  logic              first;
  logic              job_sat, job_rnd, job_tc;
  logic [OSEL_W-1:0] job_osel;
  logic              accept;
  logic              load_en;
  logic              load_first;

  assign accept     = s_valid && (state_q == ST_RUN);
  assign load_en    = accept || (state_q == ST_PAD);
  assign load_first = load_en && first;

  always_ff @(posedge MAC_ACC_CLK) begin
    if (MAC_SEQ_RST) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (cfg_len == '0) ? ST_PAD : ST_RUN;
      ST_PAD:   state_d = ST_DRAIN;
      ST_RUN:   if (accept && (cnt == LEN_W'(1))) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_HOLD;
      ST_HOLD:  if (r_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MAC_ACC_CLK) begin
    if (MAC_SEQ_RST) begin
      cnt      <= '0;
      first    <= 1'b0;
      job_sat  <= 1'b0;
      job_rnd  <= 1'b0;
      job_tc   <= 1'b0;
      job_osel <= '0;
      r_data   <= '0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        cnt      <= cfg_len;
        first    <= 1'b1;
        job_sat  <= cfg_sat;
        job_rnd  <= cfg_rnd;
        job_tc   <= cfg_tc;
        job_osel <= clamp_osel(cfg_out_sel);
      end
      if (load_en) first <= 1'b0;
      if (accept)  cnt   <= cnt - LEN_W'(1);
      if (state_q == ST_DRAIN) r_data <= MAC_OUT;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign s_ready = (state_q == ST_RUN);
  assign r_valid = (state_q == ST_HOLD);

  // Operands reach the slice only while a sample is being streamed; PAD and
  // all idle states present zeros so a load never picks up stray data.
  assign MAC_OPER_DATA      = (state_q == ST_RUN) ? s_oper : '0;
  assign MAC_COEF_DATA      = (state_q == ST_RUN) ? s_coef : '0;
  assign EFPGA_MATHB_CLK_EN = load_en;

  // RND already replaces the feedback with the rounding constant, and the
  // slice would let CLEAR override it, so exactly one of them fires.
  assign MAC_ACC_RND   = load_first && job_rnd;
  assign MAC_ACC_CLEAR = load_first && !job_rnd;

  assign MAC_ACC_SAT = job_sat;
  assign MAC_OUT_SEL = job_osel;
  assign MAC_TC      = job_tc;

endmodule

// File: tb/tb_mac_4bit_seq.sv
// tb_mac_4bit_seq
// Directed bench for mac_4bit_seq with a behavioural MAC_4BIT slice model
// attached downstream (accumulator, registered out-select, window/saturate).
module tb_mac_4bit_seq;
  import mac_seq_pkg::*;

  logic              MAC_ACC_CLK = 1'b0;
  logic              MAC_SEQ_RST = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        cfg_len = '0;
  logic [OSEL_W-1:0] cfg_out_sel = '0;
  logic              cfg_sat = 1'b0, cfg_rnd = 1'b0, cfg_tc = 1'b0;
  logic              busy;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [3:0]        s_oper = '0, s_coef = '0;
  logic [3:0]        MAC_OPER_DATA, MAC_COEF_DATA;
  logic              EFPGA_MATHB_CLK_EN, MAC_ACC_CLEAR, MAC_ACC_RND, MAC_ACC_SAT, MAC_TC;
  logic [OSEL_W-1:0] MAC_OUT_SEL;
  logic [3:0]        MAC_OUT;
  logic              r_valid;
  logic              r_ready = 1'b0;
  logic [3:0]        r_data;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 MAC_ACC_CLK = ~MAC_ACC_CLK;

  mac_4bit_seq #(.LEN_W(8)) dut (
    .MAC_ACC_CLK(MAC_ACC_CLK), .MAC_SEQ_RST(MAC_SEQ_RST), .start(start),
    .cfg_len(cfg_len), .cfg_out_sel(cfg_out_sel), .cfg_sat(cfg_sat),
    .cfg_rnd(cfg_rnd), .cfg_tc(cfg_tc), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_oper(s_oper), .s_coef(s_coef),
    .MAC_OPER_DATA(MAC_OPER_DATA), .MAC_COEF_DATA(MAC_COEF_DATA),
    .EFPGA_MATHB_CLK_EN(EFPGA_MATHB_CLK_EN), .MAC_ACC_CLEAR(MAC_ACC_CLEAR),
    .MAC_ACC_RND(MAC_ACC_RND), .MAC_ACC_SAT(MAC_ACC_SAT),
    .MAC_OUT_SEL(MAC_OUT_SEL), .MAC_TC(MAC_TC), .MAC_OUT(MAC_OUT),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
  );

  // Slice model
  logic signed [15:0] acc = '0;
  logic [OSEL_W-1:0]  osel_q = '0;
  logic signed [15:0] op_a, op_b, prod, rconst, base, shf;

  always_comb begin
    op_a   = MAC_TC ? {{12{MAC_OPER_DATA[3]}}, MAC_OPER_DATA} : {12'b0, MAC_OPER_DATA};
    op_b   = MAC_TC ? {{12{MAC_COEF_DATA[3]}}, MAC_COEF_DATA} : {12'b0, MAC_COEF_DATA};
    prod   = op_a * op_b;
    rconst = (MAC_OUT_SEL == '0) ? 16'sd0 : 16'sd1 <<< (MAC_OUT_SEL - 6'd1);
    base   = MAC_ACC_CLEAR ? 16'sd0 : (MAC_ACC_RND ? rconst : acc);
    shf    = acc >>> osel_q;
    if (!MAC_ACC_SAT)  MAC_OUT = shf[3:0];
    else if (MAC_TC)   MAC_OUT = (shf > 16'sd7) ? 4'h7 : ((shf < -16'sd8) ? 4'h8 : shf[3:0]);
    else               MAC_OUT = (shf > 16'sd15) ? 4'hF : ((shf < 16'sd0) ? 4'h0 : shf[3:0]);
  end

  always @(posedge MAC_ACC_CLK) begin
    osel_q <= MAC_OUT_SEL;
    if (EFPGA_MATHB_CLK_EN) acc <= base + prod;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Starts a job, streams len samples (optional one-cycle s_valid gap after
  // the first), checks control pulses, DRAIN timing and the captured result.
  // Leaves the bench at the first HOLD cycle.
  task automatic run_job(input string tag, input int len, input logic [5:0] sel,
                         input logic sat, input logic rnd, input logic tc,
                         input logic [15:0] ops, input logic [15:0] cfs,
                         input bit gap, input logic [3:0] exp);
    @(negedge MAC_ACC_CLK);
    cfg_len = 8'(len); cfg_out_sel = sel; cfg_sat = sat; cfg_rnd = rnd; cfg_tc = tc;
    start = 1'b1;
    @(negedge MAC_ACC_CLK);
    start = 1'b0;
    #1;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_osel"}, MAC_OUT_SEL, sel);
    chk({tag, "_sat"},  MAC_ACC_SAT, sat);
    chk({tag, "_tc"},   MAC_TC, tc);
    if (len == 0) begin
      chk({tag, "_pad_en"},  EFPGA_MATHB_CLK_EN, 1);
      chk({tag, "_pad_clr"}, MAC_ACC_CLEAR, !rnd);
      chk({tag, "_pad_rnd"}, MAC_ACC_RND, rnd);
      chk({tag, "_pad_op"},  MAC_OPER_DATA, 0);
      chk({tag, "_pad_rdy"}, s_ready, 0);
      @(negedge MAC_ACC_CLK);
    end else begin
      for (int i = 0; i < len; i++) begin
        s_valid = 1'b1; s_oper = ops[4*i +: 4]; s_coef = cfs[4*i +: 4];
        #1;
        chk({tag, "_rdy"}, s_ready, 1);
        chk({tag, "_en"},  EFPGA_MATHB_CLK_EN, 1);
        chk({tag, "_clr"}, MAC_ACC_CLEAR, (i == 0) && !rnd);
        chk({tag, "_rnd"}, MAC_ACC_RND, (i == 0) && rnd);
        chk({tag, "_op"},  MAC_OPER_DATA, ops[4*i +: 4]);
        chk({tag, "_cf"},  MAC_COEF_DATA, cfs[4*i +: 4]);
        @(negedge MAC_ACC_CLK);
        if (gap && i == 0) begin
          s_valid = 1'b0;
          #1;
          chk({tag, "_gap_en"},  EFPGA_MATHB_CLK_EN, 0);
          chk({tag, "_gap_rdy"}, s_ready, 1);
          @(negedge MAC_ACC_CLK);
        end
      end
    end
    s_valid = 1'b0;
    #1;
    chk({tag, "_drain_rv"}, r_valid, 0);
    chk({tag, "_drain_en"}, EFPGA_MATHB_CLK_EN, 0);
    chk({tag, "_drain_busy"}, busy, 1);
    @(negedge MAC_ACC_CLK);
    #1;
    chk({tag, "_rv"},   r_valid, 1);
    chk({tag, "_data"}, r_data, exp);
  endtask

  task automatic finish_job(input string tag);
    r_ready = 1'b1;
    @(negedge MAC_ACC_CLK);
    r_ready = 1'b0;
    #1;
    chk({tag, "_rv_drop"}, r_valid, 0);
    chk({tag, "_idle"},    busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge MAC_ACC_CLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rdy",  s_ready, 0);
    chk("rst_rv",   r_valid, 0);
    chk("rst_rd",   r_data, 0);
    chk("rst_en",   EFPGA_MATHB_CLK_EN, 0);
    chk("rst_ctl",  {MAC_ACC_CLEAR, MAC_ACC_RND, MAC_ACC_SAT, MAC_TC}, 0);
    chk("rst_osel", MAC_OUT_SEL, 0);
    chk("rst_ops",  {MAC_OPER_DATA, MAC_COEF_DATA}, 0);
    MAC_SEQ_RST = 1'b0;

    // 3*5 + 2*7 + 1*1 = 30
    run_job("u_sel0", 3, 6'd0, 1'b0, 1'b0, 1'b0, 16'h0123, 16'h0175, 1'b0, 4'hE);
    finish_job("u_sel0");
    run_job("u_sel2", 3, 6'd2, 1'b0, 1'b0, 1'b0, 16'h0123, 16'h0175, 1'b1, 4'h7);
    finish_job("u_sel2");
    run_job("u_sat", 3, 6'd0, 1'b1, 1'b0, 1'b0, 16'h0123, 16'h0175, 1'b0, 4'hF);
    finish_job("u_sat");
    // (-8)*(-8) = 64, window [7:4] = 4
    run_job("signed", 1, 6'd4, 1'b1, 1'b0, 1'b1, 16'h0008, 16'h0008, 1'b0, 4'h4);
    finish_job("signed");
    // rounding constant 2 + 3*1 = 5, window [5:2] = 1
    run_job("round", 1, 6'd2, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0001, 1'b0, 4'h1);
    finish_job("round");
    run_job("zero", 0, 6'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'h0);
    finish_job("zero");

    // Result backpressure with start requests that must be ignored.
    run_job("bp", 1, 6'd0, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0003, 1'b0, 4'h6);
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; cfg_out_sel = 6'd9; cfg_len = 8'd2;
      @(negedge MAC_ACC_CLK);
      #1;
      chk("bp_rv",   r_valid, 1);
      chk("bp_data", r_data, 6);
      chk("bp_busy", busy, 1);
      chk("bp_osel", MAC_OUT_SEL, 0);
    end
    start = 1'b0;
    finish_job("bp");

    // Reset in the middle of a job.
    @(negedge MAC_ACC_CLK);
    cfg_len = 8'd3; cfg_out_sel = 6'd3; cfg_sat = 1'b1; cfg_rnd = 1'b0; cfg_tc = 1'b1;
    start = 1'b1;
    @(negedge MAC_ACC_CLK);
    start = 1'b0; s_valid = 1'b1; s_oper = 4'h2; s_coef = 4'h2;
    @(negedge MAC_ACC_CLK);
    MAC_SEQ_RST = 1'b1;
    @(negedge MAC_ACC_CLK);
    MAC_SEQ_RST = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_rdy",  s_ready, 0);
    chk("mid_rv",   r_valid, 0);
    chk("mid_en",   EFPGA_MATHB_CLK_EN, 0);
    chk("mid_cfg",  {MAC_ACC_SAT, MAC_TC, MAC_OUT_SEL}, 0);
    chk("mid_ops",  {MAC_OPER_DATA, MAC_COEF_DATA}, 0);
    s_valid = 1'b0;
    run_job("post_rst", 1, 6'd0, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0003, 1'b0, 4'h6);
    finish_job("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_4bit_seq.md
# mac_4bit_seq

Job sequencer that drives one `MAC_4BIT` math-unit slice from the eFPGA fabric side. It accepts a job configuration and a stream of 4-bit operand/coefficient pairs, and sequences the slice's clock-enable, clear/round, saturation, output-select and two's-complement controls. After the last product it captures the selected 4-bit accumulator window from `MAC_OUT` and presents it on a valid/ready result port.

## Interface
- `LEN_W`, 8, width of the job length (number of products per job).
- `MAC_ACC_CLK` in 1: the single clock, shared with the MAC slice.
- `MAC_SEQ_RST` in 1: synchronous, active-high reset.
- `start` in 1: job request; sampled only in IDLE.
- `cfg_len` in LEN_W: number of products; 0 allowed.
- `cfg_out_sel` in 6: output window select, 0..16.
- `cfg_sat` in 1: saturation enable.
- `cfg_rnd` in 1: rounding enable.
- `cfg_tc` in 1: 1 = signed operands.
- `busy` out 1: high whenever the state is not IDLE.
- `s_valid` in 1, `s_ready` out 1, `s_oper` in 4, `s_coef` in 4: sample stream.
- `MAC_OPER_DATA` out 4, `MAC_COEF_DATA` out 4: operands to the slice.
- `EFPGA_MATHB_CLK_EN` out 1: accumulator load enable.
- `MAC_ACC_CLEAR` out 1, `MAC_ACC_RND` out 1: accumulator feedback control.
- `MAC_ACC_SAT` out 1, `MAC_OUT_SEL` out 6, `MAC_TC` out 1: latched job configuration.
- `MAC_OUT` in 4: slice result window.
- `r_valid` out 1, `r_ready` in 1, `r_data` out 4: result port.

## Operation
- **States:** IDLE, PAD, RUN, DRAIN, HOLD.
- **IDLE:**
  - `start`=1 latches `cfg_*` into job registers, loads `cnt`=`cfg_len`, sets `first`=1.
  - Next state is PAD if `cfg_len`==0, else RUN.
- **Latched outputs:** `MAC_ACC_SAT`, `MAC_OUT_SEL` and `MAC_TC` are driven from the job registers. They are constant from the cycle after `start` until the job returns to IDLE.
- **RUN:**
  - `s_ready`=1. `accept` = `s_valid & s_ready`.
  - `EFPGA_MATHB_CLK_EN` = `accept`.
  - `MAC_OPER_DATA`/`MAC_COEF_DATA` = `s_oper`/`s_coef`, passed combinationally.
  - On `accept`: decrement `cnt` and clear `first`. If `cnt`==1, go to DRAIN.
- **First-product control:**
  - When `accept & first`: assert `MAC_ACC_RND` if `cfg_rnd`, else assert `MAC_ACC_CLEAR`.
  - Never assert both. The slice gives CLEAR priority, and RND already replaces the feedback with the rounding constant.
  - Both are 0 on all other cycles.
- **PAD (one cycle):** `EFPGA_MATHB_CLK_EN`=1, operands 0, first-product control as above. The result therefore becomes the rounding constant or 0. Next state DRAIN.
- **DRAIN (one cycle):**
  - The accumulator and the slice's registered out-select are now valid, so `MAC_OUT` is valid.
  - Register `MAC_OUT` into `r_data` and go to HOLD.
- **HOLD:**
  - `r_valid`=1 and `r_data` stable.
  - On `r_ready`, go to IDLE. `r_valid` drops the next cycle.
- **`start` outside IDLE** is ignored.
- **`EFPGA_MATHB_CLK_EN`** is 0 in IDLE, DRAIN and HOLD, so the accumulator holds its value.
- **Reset values:**
  - State IDLE, `cnt`=0, `first`=0.
  - `busy`, `s_ready`, `r_valid`, `r_data` all 0.
  - All MAC outputs 0.
- **Reset mid-job:** return to IDLE the next cycle and drop any partial result. The slice accumulator is not cleared by this block; the next job's first product overwrites it.

## Timing
- `start` at cycle 0 gives `busy`=1 and `s_ready`=1 from cycle 1.
- A job of N products takes at least N RUN cycles, with one product per cycle when `s_valid` is held high.
- Last product accepted at edge k gives DRAIN in cycle k+1 and `r_valid` from cycle k+2. Latency is 2 cycles.
- A job of length 0: `start` at cycle 0, PAD at cycle 1, DRAIN at cycle 2, `r_valid` at cycle 3.
- The result handshake completes at the edge where `r_valid & r_ready`; IDLE follows. The earliest next `start` is accepted the cycle after.
- `s_valid` gaps in RUN stall the job with no state change.

## Structure
- Package `mac_seq_pkg`:
  - state enum `mac_seq_state_t`;
  - `MAC_DW`=4 and `OSEL_W`=6 constants;
  - `MAC_OSEL_MAX`=16.
- Single module; no sub-module is needed.
- The bench instantiates `MAC_4BIT` downstream of this block.

## Test plan
- **Unsigned, no rounding:** `cfg_tc`=0, `cfg_rnd`=0, `cfg_sat`=0, `cfg_out_sel`=0, `cfg_len`=3; samples (3,5),(2,7),(1,1) → accumulator 30, `r_data`=0xE, `r_valid` 2 cycles after the last accept.
- **Same stream, other settings:** `cfg_out_sel`=2 → `r_data`=0x7; `cfg_out_sel`=0 with `cfg_sat`=1 → `r_data`=0xF.
- **Signed:** `cfg_tc`=1, `cfg_len`=1, sample (-8,-8), `cfg_out_sel`=4, `cfg_sat`=1 → 64, `r_data`=0x4. The first cycle shows `MAC_ACC_CLEAR`=1 and `MAC_ACC_RND`=0.
- **Rounding:** `cfg_rnd`=1, `cfg_out_sel`=2, sample (3,1) → 3+2=5, `r_data`=0x1. Only `MAC_ACC_RND` pulses, on the first product.
- **Zero length:** `cfg_len`=0, `cfg_rnd`=0 → one PAD cycle with `EFPGA_MATHB_CLK_EN`=1, `r_data`=0, `r_valid` at cycle 3.
- **Backpressure and reset:**
  - Hold `r_ready`=0 for 5 cycles → `r_valid`/`r_data` stable, `start` ignored, `busy`=1.
  - Assert `MAC_SEQ_RST` mid-RUN → IDLE with all outputs 0. The next job of `cfg_len`=1, sample (2,3) returns 6 at `cfg_out_sel`=0.
